multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control.sv | 195 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multicycle controller and its
// datapath/memory. The controller uses the master view; the datapath side
// (or a testbench) uses the slave view.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       ALUSrc;
  logic       memToReg;
  logic       regWrite;
  logic       memRead;
  logic       memWrite;
  logic       branch;
  logic       jump;
  logic       instr_done;
  logic       illegal;
  logic [1:0] ALUOp;
  logic [2:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, ir_write, ALUSrc, memToReg, regWrite, memRead,
           memWrite, branch, jump, instr_done, illegal, ALUOp, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, ir_write, ALUSrc, memToReg, regWrite, memRead,
           memWrite, branch, jump, instr_done, illegal, ALUOp, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-style control FSM: IDLE -> FETCH -> DECODE -> EXEC ->
// (MEM) -> (WB) -> FETCH, with a TRAP sink for illegal opcodes and memory
// timeouts. Outputs decode the registered state/opcode (plus mem_ready for
// handshake completion pulses), so asynchronous reset clears them at once.
module multicycle_control #(
  parameter int SUPPORT_IMM = 1,
  parameter int SUPPORT_JAL = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_control_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // A zero timeout still needs a 1-bit counter so the logic stays well formed.
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [6:0]    op_q, op_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          timeout_s;

  logic       pc_write_s, ir_write_s, alu_src_s, mem_to_reg_s, reg_write_s;
  logic       mem_read_s, mem_write_s, branch_s, jump_s, instr_done_s, illegal_s;
  logic [1:0] alu_op_s;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_LOAD, OP_STORE, OP_BRANCH: op_legal = 1'b1;
      OP_IMM:                             op_legal = (SUPPORT_IMM != 0);
      OP_JAL:                             op_legal = (SUPPORT_JAL != 0);
      default:                            op_legal = 1'b0;
    endcase
  endfunction

  // Last allowed wait cycle with memory still not ready; ready wins.
  assign timeout_s = (MEM_TIMEOUT > 0) && (wait_q == WAIT_LAST) && !bus.mem_ready;

  // Next state, opcode capture and wait counter update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_DECODE: begin
        op_d    = bus.opcode;
        state_d = op_legal(bus.opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_IMM, OP_JAL: state_d = S_WB;
          OP_LOAD, OP_STORE:    state_d = S_MEM;
          OP_BRANCH:            state_d = S_FETCH;
          default:              state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
        end else if (timeout_s) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // State, opcode and wait counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= 7'b0000000;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  // Control output decode from registered state and opcode.
  always_comb begin
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    alu_src_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    alu_op_s     = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        if (bus.mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
        end else begin
          ir_write_s = 1'b0;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R:   alu_op_s = 2'b10;
          OP_IMM: begin
            alu_op_s  = 2'b10;
            alu_src_s = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            alu_op_s  = 2'b00;
            alu_src_s = 1'b1;
          end
          OP_BRANCH: begin
            alu_op_s     = 2'b01;
            branch_s     = 1'b1;
            instr_done_s = 1'b1;
          end
          OP_JAL: begin
            jump_s     = 1'b1;
            pc_write_s = 1'b1;
          end
          default: alu_op_s = 2'b00;
        endcase
      end
      S_MEM: begin
        if (op_q == OP_LOAD) begin
          mem_read_s = 1'b1;
        end else if (op_q == OP_STORE) begin
          mem_write_s  = 1'b1;
          instr_done_s = bus.mem_ready;
        end else begin
          mem_read_s = 1'b0;
        end
      end
      S_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        mem_to_reg_s = (op_q == OP_LOAD);
      end
      S_TRAP:  illegal_s = 1'b1;
      default: illegal_s = 1'b0;
    endcase
  end

  assign bus.pc_write   = pc_write_s;
  assign bus.ir_write   = ir_write_s;
  assign bus.ALUSrc     = alu_src_s;
  assign bus.memToReg   = mem_to_reg_s;
  assign bus.regWrite   = reg_write_s;
  assign bus.memRead    = mem_read_s;
  assign bus.memWrite   = mem_write_s;
  assign bus.branch     = branch_s;
  assign bus.jump       = jump_s;
  assign bus.instr_done = instr_done_s;
  assign bus.illegal    = illegal_s;
  assign bus.ALUOp      = alu_op_s;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Instance A uses default parameters;
// instance B has JAL disabled and a 4-cycle memory timeout. Each expected
// cycle is queued as it is driven and checked at the following negedge.
module tb_multicycle_control;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  // flag order: pc_write ir_write ALUSrc memToReg regWrite memRead memWrite branch jump instr_done illegal
  localparam logic [10:0] NONE = 11'b00000000000;
  localparam logic [10:0] PCW  = 11'b10000000000;
  localparam logic [10:0] IRW  = 11'b01000000000;
  localparam logic [10:0] ASRC = 11'b00100000000;
  localparam logic [10:0] M2R  = 11'b00010000000;
  localparam logic [10:0] RW   = 11'b00001000000;
  localparam logic [10:0] MR   = 11'b00000100000;
  localparam logic [10:0] MW   = 11'b00000010000;
  localparam logic [10:0] BR   = 11'b00000001000;
  localparam logic [10:0] JMP  = 11'b00000000100;
  localparam logic [10:0] DONE = 11'b00000000010;
  localparam logic [10:0] ILL  = 11'b00000000001;

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  typedef struct {
    logic [15:0] exp;
    string       tag;
    bit          sel;
  } exp_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   vectors;
  int   miscompares;
  exp_t sb_q[$];

  multicycle_control_if bus_a ();
  multicycle_control_if bus_b ();

  multicycle_control dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  multicycle_control #(
    .SUPPORT_IMM (1),
    .SUPPORT_JAL (0),
    .MEM_TIMEOUT (4)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  logic [15:0] obs_a;
  logic [15:0] obs_b;

  assign obs_a = {bus_a.state, bus_a.ALUOp, bus_a.pc_write, bus_a.ir_write, bus_a.ALUSrc,
                  bus_a.memToReg, bus_a.regWrite, bus_a.memRead, bus_a.memWrite,
                  bus_a.branch, bus_a.jump, bus_a.instr_done, bus_a.illegal};
  assign obs_b = {bus_b.state, bus_b.ALUOp, bus_b.pc_write, bus_b.ir_write, bus_b.ALUSrc,
                  bus_b.memToReg, bus_b.regWrite, bus_b.memRead, bus_b.memWrite,
                  bus_b.branch, bus_b.jump, bus_b.instr_done, bus_b.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ev(input logic [2:0] st, input logic [1:0] aluop,
                                     input logic [10:0] fl);
    return {st, aluop, fl};
  endfunction

  task automatic drive(input bit sel, input logic [6:0] op, input logic rdy);
    if (sel == B) begin
      bus_b.opcode    = op;
      bus_b.mem_ready = rdy;
    end else begin
      bus_a.opcode    = op;
      bus_a.mem_ready = rdy;
    end
  endtask

  task automatic sb_push(input bit sel, input logic [15:0] exp, input string tag);
    exp_t e;
    e.exp = exp;
    e.tag = tag;
    e.sel = sel;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t        e;
    logic [15:0] obs;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e   = sb_q.pop_front();
      obs = (e.sel == B) ? obs_b : obs_a;
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, check mid-cycle.
  task automatic step(input bit sel, input logic [6:0] op, input logic rdy,
                      input logic [15:0] exp, input string tag);
    drive(sel, op, rdy);
    sb_push(sel, exp, tag);
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  // Common FETCH (ready at once) + DECODE prefix for an instruction.
  task automatic fetch_decode(input bit sel, input logic [6:0] op, input string tag);
    step(sel, op, 1'b1, ev(3'd1, 2'b00, MR | IRW | PCW), {tag, "_fetch"});
    step(sel, op, 1'b0, ev(3'd2, 2'b00, NONE), {tag, "_decode"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_a       = 1'b1;
    rst_b       = 1'b1;
    drive(A, OP_BAD, 1'b0);
    drive(B, OP_BAD, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    sb_push(A, ev(3'd0, 2'b00, NONE), "reset_a");
    sb_check();
    sb_push(B, ev(3'd0, 2'b00, NONE), "reset_b");
    sb_check();

    // R-type: 0,1,2,3,5 then back to FETCH
    rst_a = 1'b0;
    step(A, OP_R, 1'b0, ev(3'd0, 2'b00, NONE), "r_idle");
    fetch_decode(A, OP_R, "r");
    step(A, OP_R, 1'b0, ev(3'd3, 2'b10, NONE), "r_exec");
    step(A, OP_R, 1'b0, ev(3'd5, 2'b00, RW | DONE), "r_wb");

    // Load with three wait cycles in MEM
    fetch_decode(A, OP_LD, "ld");
    step(A, OP_LD, 1'b0, ev(3'd3, 2'b00, ASRC), "ld_exec");
    for (int i = 0; i < 3; i++) begin
      step(A, OP_LD, 1'b0, ev(3'd4, 2'b00, MR), "ld_mem_wait");
    end
    step(A, OP_LD, 1'b1, ev(3'd4, 2'b00, MR), "ld_mem_ready");
    step(A, OP_LD, 1'b0, ev(3'd5, 2'b00, RW | DONE | M2R), "ld_wb");

    // Store: no regWrite, completes out of MEM
    fetch_decode(A, OP_ST, "st");
    step(A, OP_ST, 1'b0, ev(3'd3, 2'b00, ASRC), "st_exec");
    step(A, OP_ST, 1'b0, ev(3'd4, 2'b00, MW), "st_mem_wait");
    step(A, OP_ST, 1'b1, ev(3'd4, 2'b00, MW | DONE), "st_mem_ready");

    // I-type ALU, with two FETCH wait cycles first
    step(A, OP_IMM, 1'b0, ev(3'd1, 2'b00, MR), "imm_fetch_wait");
    step(A, OP_IMM, 1'b0, ev(3'd1, 2'b00, MR), "imm_fetch_wait");
    fetch_decode(A, OP_IMM, "imm");
    step(A, OP_IMM, 1'b0, ev(3'd3, 2'b10, ASRC), "imm_exec");
    step(A, OP_IMM, 1'b0, ev(3'd5, 2'b00, RW | DONE), "imm_wb");

    // Branch finishes in EXEC
    fetch_decode(A, OP_BR, "br");
    step(A, OP_BR, 1'b0, ev(3'd3, 2'b01, BR | DONE), "br_exec");

    // JAL: pc_write with jump in EXEC, then write-back
    fetch_decode(A, OP_JAL, "jal");
    step(A, OP_JAL, 1'b0, ev(3'd3, 2'b00, JMP | PCW), "jal_exec");
    step(A, OP_JAL, 1'b0, ev(3'd5, 2'b00, RW | DONE), "jal_wb");

    // All-zero opcode traps and stays trapped
    fetch_decode(A, OP_BAD, "bad");
    step(A, OP_BAD, 1'b1, ev(3'd6, 2'b00, ILL), "bad_trap");
    step(A, OP_BAD, 1'b0, ev(3'd6, 2'b00, ILL), "bad_trap_hold");

    // Asynchronous exit from TRAP, held in reset
    rst_a = 1'b1;
    #1;
    sb_push(A, ev(3'd0, 2'b00, NONE), "trap_rst_async");
    sb_check();
    step(A, OP_ST, 1'b1, ev(3'd0, 2'b00, NONE), "rst_hold");
    step(A, OP_ST, 1'b1, ev(3'd0, 2'b00, NONE), "rst_hold");

    // Reset pulsed in the middle of a store's MEM cycle
    rst_a = 1'b0;
    step(A, OP_ST, 1'b0, ev(3'd0, 2'b00, NONE), "st2_idle");
    fetch_decode(A, OP_ST, "st2");
    step(A, OP_ST, 1'b0, ev(3'd3, 2'b00, ASRC), "st2_exec");
    drive(A, OP_ST, 1'b0);
    sb_push(A, ev(3'd4, 2'b00, MW), "st2_mem");
    @(negedge clk);
    sb_check();
    #2;
    rst_a = 1'b1;
    #1;
    sb_push(A, ev(3'd0, 2'b00, NONE), "st2_mem_rst_async");
    sb_check();
    @(posedge clk);
    #1;
    sb_push(A, ev(3'd0, 2'b00, NONE), "st2_after_edge");
    sb_check();

    // Instance B: FETCH timeout after exactly four cycles
    rst_b = 1'b0;
    step(B, OP_R, 1'b0, ev(3'd0, 2'b00, NONE), "to_idle");
    for (int i = 0; i < 4; i++) begin
      step(B, OP_R, 1'b0, ev(3'd1, 2'b00, MR), "to_fetch_wait");
    end
    step(B, OP_R, 1'b1, ev(3'd6, 2'b00, ILL), "to_trap");

    // Instance B: ready on the fourth FETCH cycle wins; JAL is illegal here
    rst_b = 1'b1;
    #1;
    sb_push(B, ev(3'd0, 2'b00, NONE), "b_rst_async");
    sb_check();
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    step(B, OP_JAL, 1'b0, ev(3'd0, 2'b00, NONE), "nojal_idle");
    for (int i = 0; i < 3; i++) begin
      step(B, OP_JAL, 1'b0, ev(3'd1, 2'b00, MR), "nojal_fetch_wait");
    end
    step(B, OP_JAL, 1'b1, ev(3'd1, 2'b00, MR | IRW | PCW), "nojal_fetch_ready4");
    step(B, OP_JAL, 1'b0, ev(3'd2, 2'b00, NONE), "nojal_decode");
    step(B, OP_JAL, 1'b0, ev(3'd6, 2'b00, ILL), "nojal_trap");
    step(B, OP_JAL, 1'b1, ev(3'd6, 2'b00, ILL), "nojal_trap_hold");

    // Instance B: MEM timeout on a load
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    step(B, OP_LD, 1'b0, ev(3'd0, 2'b00, NONE), "memto_idle");
    fetch_decode(B, OP_LD, "memto");
    step(B, OP_LD, 1'b0, ev(3'd3, 2'b00, ASRC), "memto_exec");
    for (int i = 0; i < 4; i++) begin
      step(B, OP_LD, 1'b0, ev(3'd4, 2'b00, MR), "memto_mem_wait");
    end
    step(B, OP_LD, 1'b0, ev(3'd6, 2'b00, ILL), "memto_trap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
